// File: rtl/nand_phy_pkg.sv
// Shared types and constants for the NAND PHY WE#/NCLK pin arbiter.
// D1/D2 levels are the values presented to the DDR output stage.
package nand_phy_pkg;

    localparam int DEF_NUM_BUS  = 2;
    localparam int DEF_NUM_PINS = 4;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_TURN_CYC = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    typedef struct packed {
        logic d1;
        logic d2;
    } ddr_lvl_t;

    localparam ddr_lvl_t LVL_IDLE  = ddr_lvl_t'(2'b11);
    localparam ddr_lvl_t LVL_ASYNC = ddr_lvl_t'(2'b01);
    localparam ddr_lvl_t LVL_SYNC  = ddr_lvl_t'(2'b10);

endpackage

// File: rtl/nand_phy_oddr_bank.sv
// Bank of DDR output cells driving every shared WE#/NCLK pin from a common D1/D2.
// nand_phy_oddr is a behavioural stand-in for ODDR (OPPOSITE_EDGE, SYNC set/reset).
module nand_phy_oddr (
    input  logic c_i,
    input  logic ce_i,
    input  logic r_i,
    input  logic s_i,
    input  logic d1_i,
    input  logic d2_i,
    output logic q_o
);
    logic q1_q;
    logic q2_q;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge c_i) begin
        if (r_i)       q1_q <= 1'b0;
        else if (s_i)  q1_q <= 1'b1;
        else if (ce_i) q1_q <= d1_i;
    end

    always_ff @(negedge c_i) begin
        if (r_i)       q2_q <= 1'b0;
        else if (s_i)  q2_q <= 1'b1;
        else if (ce_i) q2_q <= d2_i;
    end

    assign q_o = c_i ? q1_q : q2_q;
endmodule

module nand_phy_oddr_bank #(
    parameter int NUM_PINS = 4
) (
    input  logic                clk_i,
    input  logic                d1_i,
    input  logic                d2_i,
    output logic [NUM_PINS-1:0] q_o
);
    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        nand_phy_oddr u_oddr (
            .c_i  (clk_i),
            .ce_i (1'b1),
            .r_i  (1'b0),
            .s_i  (1'b0),
            .d1_i (d1_i),
            .d2_i (d2_i),
            .q_o  (q_o[p])
        );
    end
endmodule

// File: rtl/nand_phy_wen_nclk_arb.sv
// Round-robin arbiter granting bus controllers bursts of WE# pulses or NCLK toggles
// on the shared pins, with a programmable idle turnaround between owners.
module nand_phy_wen_nclk_arb
    import nand_phy_pkg::*;
#(
    parameter int NUM_BUS  = DEF_NUM_BUS,
    parameter int NUM_PINS = DEF_NUM_PINS,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TURN_CYC = DEF_TURN_CYC
) (
    input  logic                     v_clk0,
    input  logic                     v_rst0,
    input  logic [NUM_BUS-1:0]       v_ctrl_req,
    input  logic [NUM_BUS-1:0]       v_ctrl_mode,
    input  logic [NUM_BUS*CNT_W-1:0] v_ctrl_cnt,
    input  logic                     v_abort,
    output logic [NUM_BUS-1:0]       v_ctrl_ack,
    output logic [NUM_BUS-1:0]       v_ctrl_done,
    output logic                     v_busy,
    output logic [NUM_PINS-1:0]      v_wen_nclk_shared
);
    localparam int BUS_W = (NUM_BUS > 1) ? $clog2(NUM_BUS) : 1;
    localparam int GAP_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    state_e             state_q, state_d;
    logic [BUS_W-1:0]   ptr_q, ptr_d;
    logic [BUS_W-1:0]   owner_q, owner_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    ddr_lvl_t           lvl_q, lvl_d;
    logic               hold_q;
    logic [BUS_W-1:0]   grant_idx;
    logic               grant_vld;
    logic               to_gap;
    logic [NUM_BUS-1:0] ack_c, done_c;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_BUS; i++) begin
            if (!grant_vld && v_ctrl_req[(int'(ptr_q) + i) % NUM_BUS]) begin
                grant_vld = 1'b1;
                grant_idx = BUS_W'((int'(ptr_q) + i) % NUM_BUS);
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        ack_c   = '0;
        done_c  = '0;
        to_gap  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // hold_q blocks a grant in the first cycle after reset releases.
                if (grant_vld && !hold_q) begin
                    ack_c[grant_idx] = 1'b1;
                    owner_d = grant_idx;
                    mode_d  = v_ctrl_mode[grant_idx];
                    rem_d   = v_ctrl_cnt[int'(grant_idx)*CNT_W +: CNT_W];
                    ptr_d   = (int'(grant_idx) == NUM_BUS - 1) ? '0 : grant_idx + 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (v_abort) begin
                    rem_d  = '0;
                    to_gap = 1'b1;
                end else if (rem_q == '0) begin
                    done_c[owner_q] = 1'b1;
                    to_gap = 1'b1;
                end else begin
                    rem_d = rem_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) state_d = ST_IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (to_gap) begin
            if (TURN_CYC == 0) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_GAP;
                gap_d   = GAP_W'(TURN_CYC - 1);
            end
        end

        // Level is decided from next state, so the registered D1/D2 lines up with the pulse cycle.
        lvl_d = LVL_IDLE;
        if (state_d == ST_RUN && rem_d != '0) lvl_d = mode_d ? LVL_SYNC : LVL_ASYNC;
    end

    always_ff @(posedge v_clk0) begin
        if (v_rst0) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            mode_q  <= 1'b0;
            rem_q   <= '0;
            gap_q   <= '0;
            lvl_q   <= LVL_IDLE;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            lvl_q   <= lvl_d;
            hold_q  <= 1'b0;
        end
    end

    assign v_ctrl_ack  = v_rst0 ? '0 : ack_c;
    assign v_ctrl_done = v_rst0 ? '0 : done_c;
    assign v_busy      = !v_rst0 && (state_q != ST_IDLE);

    nand_phy_oddr_bank #(
        .NUM_PINS (NUM_PINS)
    ) u_oddr_bank (
        .clk_i (v_clk0),
        .d1_i  (lvl_q.d1),
        .d2_i  (lvl_q.d2),
        .q_o   (v_wen_nclk_shared)
    );
endmodule
